reg_file_sb: RTL and testbench



---
 rtl/reg_file_sb.sv | 74 +++++++
 tb/tb_reg_file_sb.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with zero register, busy scoreboard and post-reset clear sequencer.
// Optional write-before-read forwarding when REGFILE_BYPASS_EN is defined.
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [DATA_W-1:0] PA,
    output logic [DATA_W-1:0] PB,
    input  logic [ADDR_W-1:0] RW,
    input  logic [DATA_W-1:0] PW,
    input  logic              LE,
    input  logic              SB_SET,
    input  logic [ADDR_W-1:0] SB_ADDR,
    output logic              BUSY_A,
    output logic              BUSY_B,
    output logic              READY
);
    localparam int DEPTH = 2**ADDR_W;
    typedef enum logic {CLEAR, RUN} state_t;
    state_t            state_q;
    logic              ready_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              run, wr_en, byp_a, byp_b;
    assign run   = state_q == RUN;
    assign wr_en = run && LE && RW != '0;
`ifdef REGFILE_BYPASS_EN
    assign byp_a = wr_en && RA == RW;
    assign byp_b = wr_en && RB == RW;
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif
    // A new producer issuing on the same edge as a write-back keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) busy_d[RW] = 1'b0;
        if (run && SB_SET && SB_ADDR != '0) busy_d[SB_ADDR] = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            ready_q <= 1'b0;
            cnt_q   <= ADDR_W'(1);
            busy_q  <= '0;
        end else begin
            busy_q <= busy_d;
            if (state_q == CLEAR) begin
                cnt_q <= cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                end
            end
        end
    end
    // Register 0 is never stored to; reads of it are forced to zero below.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) regs_q[cnt_q] <= '0;
            else if (wr_en) regs_q[RW] <= PW;
        end
    end
    assign PA     = !run ? '0 : byp_a ? PW : RA == '0 ? '0 : regs_q[RA];
    assign PB     = !run ? '0 : byp_b ? PW : RB == '0 ? '0 : regs_q[RB];
    assign BUSY_A = run && !byp_a && busy_q[RA];
    assign BUSY_B = run && !byp_b && busy_q[RB];
    assign READY  = ready_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed and random checks of reg_file_sb against an array-based reference model.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        reset, LE, SB_SET;
    logic [4:0]  RA, RB, RW, SB_ADDR;
    logic [31:0] PW, PA, PB;
    logic        BUSY_A, BUSY_B, READY;
    int          checks = 0, errors = 0;
    logic [31:0] m_reg [32];
    bit          m_busy [32];
    bit          m_run;
    int          m_edges;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .RA(RA), .RB(RB), .PA(PA), .PB(PB),
        .RW(RW), .PW(PW), .LE(LE), .SB_SET(SB_SET), .SB_ADDR(SB_ADDR),
        .BUSY_A(BUSY_A), .BUSY_B(BUSY_B), .READY(READY)
    );

    always #5 clk = ~clk;

    function automatic bit byp(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
        return m_run && LE && RW != 0 && a == RW;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_p(input logic [4:0] a);
        if (!m_run) return 32'h0;
        if (byp(a)) return PW;
        return a == 0 ? 32'h0 : m_reg[a];
    endfunction

    function automatic logic exp_b(input logic [4:0] a);
        return m_run && !byp(a) && m_busy[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        #1;
        chk("PA", PA, exp_p(RA));
        chk("PB", PB, exp_p(RB));
        chk("BUSY_A", {31'h0, BUSY_A}, {31'h0, exp_b(RA)});
        chk("BUSY_B", {31'h0, BUSY_B}, {31'h0, exp_b(RB)});
        chk("READY", {31'h0, READY}, {31'h0, m_run});
    endtask

    // Apply one rising edge; the model follows the rules with the inputs present at the edge.
    task automatic tick(input bit c);
        if (c) chk_all(); else #1;
        @(posedge clk);
        if (reset) begin
            m_run = 0;
            m_edges = 0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end else if (!m_run) begin
            m_edges++;
            m_reg[m_edges] = 32'h0;
            if (m_edges == 31) m_run = 1;
        end else begin
            if (LE && RW != 0) begin
                m_reg[RW] = PW;
                m_busy[RW] = 0;
            end
            if (SB_SET && SB_ADDR != 0) m_busy[SB_ADDR] = 1;
        end
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        LE = 1; RW = a; PW = d;
        tick(1);
        LE = 0;
    endtask

    initial begin
        foreach (m_reg[i]) m_reg[i] = 32'h0;
        foreach (m_busy[i]) m_busy[i] = 0;
        m_run = 0; m_edges = 0;
        reset = 1; LE = 0; SB_SET = 0; RA = 0; RB = 0; RW = 0; SB_ADDR = 0; PW = 0;
        tick(0); tick(0);
        chk_all();
        chk("rst_ready", {31'h0, READY}, 32'h0);
        // clear sequence with a write held on LE that must be ignored
        reset = 0; LE = 1; RW = 3; PW = 32'hFFFF_FFFF; RA = 3; RB = 3;
        repeat (30) tick(1);
        #1 chk("ready_edge30", {31'h0, READY}, 32'h0);
        tick(1);
        LE = 0;
        #1 chk("ready_edge31", {31'h0, READY}, 32'h1);
        chk("clr_r3", PA, 32'h0);
        // basic read/write
        wr(7, 32'hDEAD_BEEF);
        wr(31, 32'h1234_5678);
        RA = 7; RB = 31;
        #1 chk("rw_pa7", PA, 32'hDEAD_BEEF);
        chk("rw_pb31", PB, 32'h1234_5678);
        RB = 7;
        #1 chk("same_pa", PA, 32'hDEAD_BEEF);
        chk("same_pb", PB, 32'hDEAD_BEEF);
        // zero register
        wr(0, 32'hABCD);
        RA = 0;
        #1 chk("zero_pa", PA, 32'h0);
        SB_SET = 1; SB_ADDR = 0;
        tick(1);
        SB_SET = 0;
        #1 chk("zero_busy", {31'h0, BUSY_A}, 32'h0);
        // scoreboard
        SB_SET = 1; SB_ADDR = 5;
        tick(1);
        SB_SET = 0; RA = 5;
        #1 chk("sb_set5", {31'h0, BUSY_A}, 32'h1);
        wr(5, 32'h55);
        #1 chk("sb_clr5", {31'h0, BUSY_A}, 32'h0);
        chk("sb_pa5", PA, 32'h55);
        LE = 1; RW = 9; PW = 32'h99; SB_SET = 1; SB_ADDR = 9;
        tick(1);
        LE = 0; SB_SET = 0; RA = 9;
        #1 chk("sb_setwins", {31'h0, BUSY_A}, 32'h1);
        chk("sb_pa9", PA, 32'h99);
        // bypass
        wr(12, 32'h1);
        RA = 12; RB = 7; LE = 1; RW = 12; PW = 32'hCAFE;
`ifdef REGFILE_BYPASS_EN
        #1 chk("byp_pre", PA, 32'hCAFE);
`else
        #1 chk("byp_pre", PA, 32'h1);
`endif
        tick(1);
        LE = 0;
        #1 chk("byp_post", PA, 32'hCAFE);
        // reset mid-operation
        wr(4, 32'h44);
        SB_SET = 1; SB_ADDR = 6;
        tick(1);
        SB_SET = 0; reset = 1;
        tick(1);
        reset = 0; RA = 4;
        #1 chk("mid_ready", {31'h0, READY}, 32'h0);
        chk("mid_pa4", PA, 32'h0);
        repeat (30) tick(1);
        #1 chk("mid_ready30", {31'h0, READY}, 32'h0);
        tick(1);
        #1 chk("mid_ready31", {31'h0, READY}, 32'h1);
        for (int i = 0; i < 32; i++) begin
            RA = 5'(i); RB = 5'(31 - i);
            #1 chk("post_busy", {31'h0, BUSY_A}, 32'h0);
            chk("post_pa", PA, 32'h0);
        end
        // random traffic with rare resets
        for (int n = 0; n < 600; n++) begin
            reset   = $urandom_range(0, 149) == 0;
            LE      = $urandom_range(0, 1);
            RW      = 5'($urandom);
            PW      = $urandom;
            SB_SET  = $urandom_range(0, 2) == 0;
            SB_ADDR = $urandom_range(0, 3) == 0 ? RW : 5'($urandom);
            RA      = $urandom_range(0, 3) == 0 ? RW : 5'($urandom);
            RB      = $urandom_range(0, 3) == 0 ? RA : 5'($urandom);
            tick(1);
        end
        reset = 0;
        tick(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
